alu_share_arb: RTL

Two-port arbiter and pipeline controller that shares the single 32-bit ALU between two requesters, e.g. the integer issue slot and the address/branch unit. Each requester presents an ALUC code and two operands with a request/grant handshake. The block selects one request per cycle, holds it in an issue register that drives the ALU, and captures the ALU output into a result register. That register is returned with requester ID, carry and error flags under valid/ready backpressure.

---
 rtl/alu_share_arb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Shares one combinational ALU between two requesters. Each
//               cycle at most one request is granted and loaded into an issue
//               register that drives the ALU. The ALU output is captured in a
//               result register that is returned under valid/ready.
//               Two-stage pipeline, grant-to-result latency of 2 cycles,
//               full throughput of 1 op/cycle.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               req0/1, aluc0/1,
//               opa0/1, opb0/1       - requester op and operands
//               gnt0/1               - combinational grant, one-hot or zero
//               alu_a/b/c            - ALU operands/op, from issue register
//               alu_out, alu_carry   - ALU result and adder carry
//               res_valid/ready      - result handshake
//               res_id, res,
//               res_carry, res_err   - result payload
// Config      : `define ALU_ARB_RR_EN for round-robin arbitration; when
//               undefined requester 0 always wins and no pointer is built.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [CTRL_WIDTH-1:0] aluc0,
    input  logic [CTRL_WIDTH-1:0] aluc1,
    input  logic [DATA_WIDTH-1:0] opa0,
    input  logic [DATA_WIDTH-1:0] opb0,
    input  logic [DATA_WIDTH-1:0] opa1,
    input  logic [DATA_WIDTH-1:0] opb1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [CTRL_WIDTH-1:0] alu_c,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_carry,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  res_carry,
    output logic                  res_err
);

    localparam logic [CTRL_WIDTH-1:0] c_ALUC_ILLEGAL = CTRL_WIDTH'(4'b1011);

    // Issue stage
    logic                  r_iss_valid;
    logic                  r_iss_id;
    logic [CTRL_WIDTH-1:0] r_iss_c;
    logic [DATA_WIDTH-1:0] r_iss_a;
    logic [DATA_WIDTH-1:0] r_iss_b;

    // Result stage
    logic                  r_res_valid;
    logic                  r_res_id;
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_res_carry;
    logic                  r_res_err;

    logic w_adv1;
    logic w_adv2;
    logic w_grant_en;
    logic w_pick1;
    logic w_gnt;
    logic w_illegal;
    logic w_is_add;

    // The result stage may move when it is empty or being consumed; the issue
    // stage may move when it is empty or its contents can move on.
    assign w_adv2     = !r_res_valid || res_ready;
    assign w_adv1     = !r_iss_valid || w_adv2;
    assign w_grant_en = w_adv1 && !rst;

`ifdef ALU_ARB_RR_EN
    // r_ptr = 1 means requester 1 wins the next conflict.
    logic r_ptr;

    assign w_pick1 = req1 && (!req0 || r_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_gnt) begin
            // Hand priority to the requester that was not just served.
            r_ptr <= gnt0;
        end
    end
`else
    assign w_pick1 = req1 && !req0;
`endif

    assign gnt1  = w_grant_en && w_pick1;
    assign gnt0  = w_grant_en && req0 && !w_pick1;
    assign w_gnt = gnt0 || gnt1;

    assign w_illegal = (r_iss_c == c_ALUC_ILLEGAL);
    // Only the ADD encodings (x000) carry a meaningful adder carry out.
    assign w_is_add  = (r_iss_c[2:0] == 3'b000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_id    <= 1'b0;
            r_iss_c     <= '0;
            r_iss_a     <= '0;
            r_iss_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res       <= '0;
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_iss_valid <= 1'b1;
                r_iss_id    <= gnt1;
                r_iss_c     <= gnt1 ? aluc1 : aluc0;
                r_iss_a     <= gnt1 ? opa1  : opa0;
                r_iss_b     <= gnt1 ? opb1  : opb0;
            end else if (w_adv2) begin
                // Operands are kept so the ALU inputs do not toggle on bubbles.
                r_iss_valid <= 1'b0;
            end

            if (w_adv2) begin
                r_res_valid <= r_iss_valid;
                r_res_id    <= r_iss_id;
                r_res_err   <= w_illegal;
                r_res       <= w_illegal ? '0 : alu_out;
                r_res_carry <= !w_illegal && w_is_add && alu_carry;
            end
        end
    end

    assign alu_a     = r_iss_a;
    assign alu_b     = r_iss_b;
    assign alu_c     = r_iss_c;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res       = r_res;
    assign res_carry = r_res_carry;
    assign res_err   = r_res_err;

endmodule
`default_nettype wire
